input_loader: RTL and testbench

- Upstream stage of the vocabulary matcher.
- Accepts an input word as a valid/ready byte stream and writes it into the input memory region starting at `input_start_addr`.
- Appends the 0x00 terminator that the matcher uses as end-of-word.
- Then raises the matcher's `cs` for exactly one cycle, together with the stored length.
- Detects region overflow and illegal embedded 0x00 bytes.

---
 rtl/input_loader.sv | 138 +++++++++++++
 tb/tb_input_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_loader.sv
// Input loader: writes a valid/ready byte stream into the matcher's input region,
// appends the 0x00 terminator and pulses cs. Optional macro: LOADER_CASE_FOLD_EN.
module input_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] input_start_addr,
    input  logic [ADDR_WIDTH-1:0] input_end_addr,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cs,
    output logic [ADDR_WIDTH-1:0] word_len,
    output logic                  err,
    output logic [1:0]            err_cause,
    output logic [2:0]            state_dbg
);

    // Stream handshake: a byte transfers on a rising edge where s_valid && s_ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TERM  = 3'd2,
        S_START = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] start_q, end_q, wr_ptr, count;
    logic [ADDR_WIDTH-1:0] capacity;
    logic [DATA_WIDTH-1:0] in_byte;
    logic                  data_wr, term_wr;
    logic [1:0]            err_set;

    // The last slot of the region is always kept free for the terminator.
    assign capacity  = end_q - start_q;
    assign state_dbg = state;

    always_comb begin
        in_byte = s_data;
`ifdef LOADER_CASE_FOLD_EN
        if (DATA_WIDTH == 8 && s_data >= DATA_WIDTH'(8'h41) && s_data <= DATA_WIDTH'(8'h5A))
            in_byte = s_data + DATA_WIDTH'(8'h20);
`endif
    end

    always_comb begin
        state_d = state;
        s_ready = 1'b0;
        data_wr = 1'b0;
        term_wr = 1'b0;
        err_set = 2'b00;
        case (state)
            S_IDLE: begin
                if (load_en) state_d = S_LOAD;
            end
            S_LOAD: begin
                s_ready = (count < capacity);
                if (s_valid && s_ready) begin
                    if (in_byte == '0) begin
                        err_set = 2'b10;
                        state_d = S_ERR;
                    end else begin
                        data_wr = 1'b1;
                        if (s_last) state_d = S_TERM;
                    end
                end else if (s_valid) begin
                    err_set = 2'b01;
                    state_d = S_ERR;
                end
            end
            S_TERM: begin
                term_wr = 1'b1;
                state_d = S_START;
            end
            S_START: state_d = S_DONE;
            S_DONE: begin
                if (!load_en) state_d = S_IDLE;
            end
            S_ERR: begin
                if (!load_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cs        <= 1'b0;
            word_len  <= '0;
            err       <= 1'b0;
            err_cause <= 2'b00;
        end else begin
            state  <= state_d;
            mem_we <= data_wr | term_wr;
            cs     <= (state == S_TERM);
            err    <= (state_d == S_ERR);
            if (state == S_IDLE && load_en) begin
                start_q <= input_start_addr;
                end_q   <= input_end_addr;
                wr_ptr  <= input_start_addr;
                count   <= '0;
            end
            if (data_wr) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= in_byte;
                wr_ptr    <= wr_ptr + 1'b1;
                count     <= count + 1'b1;
            end
            if (term_wr) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= '0;
                word_len  <= count;
            end
            if (err_set != 2'b00)
                err_cause <= err_set;
            else if (state == S_ERR && !load_en)
                err_cause <= 2'b00;
        end
    end

endmodule

// File: tb/tb_input_loader.sv
// Bench for input_loader: a per-load transaction model predicts writes, cs, ready and
// error outputs; a negedge compare process checks them every cycle.
module tb_input_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [3:0] input_start_addr, input_end_addr;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready, mem_we, cs, err;
    logic [3:0] mem_addr, word_len;
    logic [7:0] mem_wdata;
    logic [1:0] err_cause;
    logic [2:0] state_dbg;

    input_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load_en(load_en),
        .input_start_addr(input_start_addr), .input_end_addr(input_end_addr),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cs(cs), .word_len(word_len), .err(err), .err_cause(err_cause),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // exp_q entry: [47:16] cycle, [15:12] addr, [11:4] data.  cs_q entry: [47:16] cycle, [3:0] len.
    logic [47:0] exp_q[$];
    logic [47:0] cs_q[$];
    logic        exp_ready = 1'b0, exp_err = 1'b0;
    logic [1:0]  exp_cause = 2'b00;
    bit          chk_en = 1'b0;
    int          checks = 0, errors = 0;
    int          load_cyc = 0, last_cs_cyc = 0;
    logic [7:0]  mem_img[16];
    logic [7:0]  stim[8];
    int          stim_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fold(input logic [7:0] d);
`ifdef LOADER_CASE_FOLD_EN
        if (d >= 8'h41 && d <= 8'h5A) return d + 8'h20;
`endif
        return d;
    endfunction

    task automatic set_stim(input int n, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
        stim_n = n;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) mem_img[i] = 8'hee;
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        logic        we_exp, cs_exp;
        if (chk_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < cyc) begin
                chk("missed_write", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            while (cs_q.size() > 0 && int'(cs_q[0][47:16]) < cyc) begin
                chk("missed_cs", 32'd0, 32'd1);
                void'(cs_q.pop_front());
            end
            we_exp = (exp_q.size() > 0 && int'(exp_q[0][47:16]) == cyc);
            cs_exp = (cs_q.size() > 0 && int'(cs_q[0][47:16]) == cyc);
            chk("mem_we", {31'd0, mem_we}, {31'd0, we_exp});
            if (we_exp) begin
                e = exp_q.pop_front();
                chk("mem_addr", {28'd0, mem_addr}, {28'd0, e[15:12]});
                chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e[11:4]});
            end
            chk("cs", {31'd0, cs}, {31'd0, cs_exp});
            if (cs_exp) begin
                e = cs_q.pop_front();
                chk("word_len", {28'd0, word_len}, {28'd0, e[3:0]});
            end
            chk("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("err_cause", {30'd0, err_cause}, {30'd0, exp_cause});
        end
        if (mem_we === 1'b1) mem_img[mem_addr] = mem_wdata;
        if (cs === 1'b1) last_cs_cyc = cyc;
    end

    // Drives one load from IDLE and records what the outputs must do, back to IDLE.
    task automatic do_load(input logic [3:0] st, input logic [3:0] en, input int stall_last);
        logic [3:0] cap;
        logic [3:0] addr;
        logic [7:0] b;
        int         cnt;
        cap = en - st;
        cnt = 0;
        input_start_addr = st;
        input_end_addr   = en;
        load_en = 1'b1;
        tick();
        load_cyc  = cyc;
        exp_ready = (cap != 4'd0);
        for (int i = 0; i < stim_n; i++) begin
            if (i == stim_n - 1) begin
                repeat (stall_last) begin
                    s_valid = 1'b0;
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = stim[i];
            s_last  = (i == stim_n - 1);
            b = fold(stim[i]);
            if (cnt >= int'(cap)) begin
                tick();
                exp_ready = 1'b0; exp_err = 1'b1; exp_cause = 2'b01;
                break;
            end
            if (b == 8'h00) begin
                tick();
                exp_ready = 1'b0; exp_err = 1'b1; exp_cause = 2'b10;
                break;
            end
            tick();
            addr = st + 4'(cnt);
            exp_q.push_back({32'(cyc), addr, b, 4'd0});
            cnt++;
            if (i == stim_n - 1) begin
                exp_ready = 1'b0;
                addr = st + 4'(cnt);
                exp_q.push_back({32'(cyc + 1), addr, 8'h00, 4'd0});
                cs_q.push_back({32'(cyc + 1), 12'd0, 4'(cnt)});
                break;
            end
            exp_ready = (cnt < int'(cap));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (4) tick();
        load_en = 1'b0;
        tick();
        exp_err = 1'b0; exp_cause = 2'b00;
        tick();
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; input_start_addr = 4'd0; input_end_addr = 4'd0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        clear_img();
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_mem_addr", {28'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("reset_word_len", {28'd0, word_len}, 32'd0);
        chk("reset_state", {29'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        tick();

        // basic word "cat", then the same word with a 2-cycle stall before the last byte
        set_stim(3, 8'h63, 8'h61, 8'h74, 8'h00);
        do_load(4'd0, 4'd15, 0);
        chk("cat_mem0", {24'd0, mem_img[0]}, 32'h63);
        chk("cat_mem1", {24'd0, mem_img[1]}, 32'h61);
        chk("cat_mem2", {24'd0, mem_img[2]}, 32'h74);
        chk("cat_mem3", {24'd0, mem_img[3]}, 32'h00);
        chk("cat_cs_latency", 32'(last_cs_cyc - load_cyc), 32'd4);
        chk("cat_word_len", {28'd0, word_len}, 32'd3);
        clear_img();
        do_load(4'd0, 4'd15, 2);
        chk("stall_mem2", {24'd0, mem_img[2]}, 32'h74);
        chk("stall_mem3", {24'd0, mem_img[3]}, 32'h00);
        chk("stall_cs_latency", 32'(last_cs_cyc - load_cyc), 32'd6);

        // overflow: capacity 3, four bytes offered
        clear_img();
        set_stim(4, 8'h61, 8'h62, 8'h63, 8'h64);
        do_load(4'd0, 4'd3, 0);
        chk("ovf_no_term", {24'd0, mem_img[3]}, 32'hee);
        chk("ovf_mem2", {24'd0, mem_img[2]}, 32'h63);

        // exact fill: terminator lands in the reserved slot
        set_stim(3, 8'h61, 8'h62, 8'h63, 8'h00);
        do_load(4'd0, 4'd3, 0);
        chk("fill_term", {24'd0, mem_img[3]}, 32'h00);

        // embedded zero
        clear_img();
        set_stim(3, 8'h61, 8'h00, 8'h62, 8'h00);
        do_load(4'd0, 4'd15, 0);
        chk("zero_mem1_untouched", {24'd0, mem_img[1]}, 32'hee);

        // wrapping region 14..1
        clear_img();
        set_stim(3, 8'h61, 8'h62, 8'h63, 8'h00);
        do_load(4'd14, 4'd1, 0);
        chk("wrap_mem14", {24'd0, mem_img[14]}, 32'h61);
        chk("wrap_mem15", {24'd0, mem_img[15]}, 32'h62);
        chk("wrap_mem0", {24'd0, mem_img[0]}, 32'h63);
        chk("wrap_mem1", {24'd0, mem_img[1]}, 32'h00);

        // zero capacity
        set_stim(1, 8'h61, 8'h00, 8'h00, 8'h00);
        do_load(4'd5, 4'd5, 0);

        // case folding
        clear_img();
        set_stim(3, 8'h43, 8'h61, 8'h54, 8'h00);
        do_load(4'd0, 4'd15, 0);
`ifdef LOADER_CASE_FOLD_EN
        chk("fold_mem0", {24'd0, mem_img[0]}, 32'h63);
        chk("fold_mem2", {24'd0, mem_img[2]}, 32'h74);
`else
        chk("fold_mem0", {24'd0, mem_img[0]}, 32'h43);
        chk("fold_mem2", {24'd0, mem_img[2]}, 32'h54);
`endif

        // reset in the middle of a load, with a third byte on the bus
        clear_img();
        input_start_addr = 4'd0; input_end_addr = 4'd15; load_en = 1'b1;
        tick();
        exp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 8'h61 + 8'(i); s_last = 1'b0;
            tick();
            exp_q.push_back({32'(cyc), 4'(i), 8'h61 + 8'(i), 4'd0});
        end
        s_data = 8'h63; rst = 1'b1;
        tick();
        exp_ready = 1'b0;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_word_len", {28'd0, word_len}, 32'd0);
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        rst = 1'b0; s_valid = 1'b0; load_en = 1'b0;
        repeat (4) tick();
        chk("rst_no_term", {24'd0, mem_img[2]}, 32'hee);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("cs_q_drained", 32'(cs_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
